gpio_pad_ctrl: RTL and testbench
================================

// Module: gpio_pad_ctrl
// PURPOSE
//  Register-programmed control stage feeding the openframe GPIO pad wrapper.
//  Per pad, it drives the pad output value, output enable (oeb), input disable and drive mode (dm2..dm0).
//  It also samples pad inputs via a 2-flop synchronizer, detects rising/falling edges into sticky W1C status,
//  and raises a level interrupt. One instance per pad bank, between the core register bus and the pad wrapper.
// PARAMETERS
//  NPADS   6   number of pads controlled (1..32)
// PORTS
//  mclk          in   1      core clock; all state on rising edge
//  reset         in   1      synchronous, active-high reset
//  reg_cs        in   1      register access request
//  reg_wr        in   1      1=write, 0=read (qualified by reg_cs)
//  reg_addr      in   4      register index
//  reg_wdata     in   NPADS  write data, bit i = pad i
//  reg_rdata     out  NPADS  read data, valid while reg_ack=1
//  reg_ack       out  1      one-cycle access acknowledge
//  pad_in        in   NPADS  raw pad input (asynchronous)
//  pad_out       out  NPADS  pad output value
//  pad_oeb       out  NPADS  output enable, active low
//  pad_inp_dis   out  NPADS  input buffer disable
//  pad_dm2/1/0   out  NPADS  drive-mode bits per pad
//  irq           out  1      level interrupt
// BEHAVIOUR
//  Registers (addr: name, access, reset):
//   0 DOUT RW 0 | 1 OE RW 0 | 2 DIN RO | 3 INP_DIS RW 0 | 4 PULL_EN RW 0
//   5 PULL_UP RW 0 | 6 RISE_EN RW 0 | 7 FALL_EN RW 0 | 8 INT_STAT RW1C 0
//   Addresses 9..15 read 0; writes to them are ignored.
//  Handshake:
//   - Access accepted on an edge where reg_cs=1 and reg_ack=0.
//   - reg_ack is registered: high exactly the following cycle.
//   - A held reg_cs yields ack every 2nd cycle.
//   - Writes update registers on the accept edge.
//   - reg_rdata is registered on the accept edge and held until the next accept. Reset value 0.
//  Pad drive (combinational from registers, so it changes the cycle after the write edge):
//   - pad_oeb = ~OE.
//   - pad_inp_dis = INP_DIS.
//   - OE=1: dm=110, pad_out=DOUT.
//   - OE=0, PULL_EN=1, PULL_UP=1: dm=011, pad_out=1.
//   - OE=0, PULL_EN=1, PULL_UP=0: dm=010, pad_out=0.
//   - OE=0, PULL_EN=0: dm=001, pad_out=DOUT.
//  Reset values of the pad outputs: pad_oeb all 1, dm=001, pad_out 0, pad_inp_dis 0, irq 0, reg_ack 0.
//  Input path:
//   - s1 <= pad_in & ~INP_DIS; s2 <= s1; s3 <= s2. DIN reads s2.
//   - rise = s2 & ~s3 & RISE_EN; fall = ~s2 & s3 & FALL_EN.
//   - INT_STAT[i] sets on rise|fall. Cleared by writing 1 on the accept edge.
//   - Set and clear on the same edge: set wins.
//  irq: registered, = |(INT_STAT & (RISE_EN|FALL_EN)), so one cycle after the status change.
//  Latency pad_in 0->1 to INT_STAT set: 3 edges. To irq: 4 edges.
//  Reset is synchronous and takes priority over any access or edge on the same edge:
//   - all registers and sync flops return to 0;
//   - an in-flight ack is dropped (reg_ack 0 next cycle).
//  Glitch shorter than one mclk period may be missed. No requirement to catch it.
//  Bits above NPADS in any register do not exist; reg_wdata/rdata are NPADS wide.
// TESTING
//  T1 reset: reset high 2 cycles -> pad_oeb=all 1, dm2/1/0=0/0/1, reg_ack=0, irq=0, all reads 0.
//  T2 drive: write OE=0x3F, then DOUT=0x15 -> next cycle pad_oeb=0x00, pad_out=0x15, dm=110 on all pads.
//  T3 pulls: OE=0, PULL_EN=0x03, PULL_UP=0x01 -> pad0 dm=011 out=1; pad1 dm=010 out=0; others dm=001.
//  T4 edge/irq: RISE_EN=0x04, pad_in[2] 0->1 -> INT_STAT=0x04 after 3 edges, irq=1 after 4.
//     Write INT_STAT=0x04 -> irq=0 two cycles later.
//  T5 race: write INT_STAT W1C bit0 on the same edge a fall on pad0 is detected (FALL_EN[0]=1)
//     -> INT_STAT[0] stays 1.
//  T6 handshake/reset: reg_cs held 6 cycles -> exactly 3 acks.
//     Assert reset in the ack-pending cycle -> reg_ack=0 and written register=0.

Source files
------------

// File: rtl/gpio_pad_ctrl_if.sv
// gpio_pad_ctrl_if
//   Register bus between the core and one GPIO pad bank controller.
//   reg_cs    : access request, held until reg_ack is seen
//   reg_wr    : 1 = write, 0 = read (qualified by reg_cs)
//   reg_addr  : register index 0..15
//   reg_wdata : write data, bit i = pad i
//   reg_rdata : read data, valid while reg_ack = 1, held until the next access
//   reg_ack   : one-cycle acknowledge, the cycle after the access is accepted
interface gpio_pad_ctrl_if #(
    parameter int NPADS = 6
);
    logic             reg_cs;
    logic             reg_wr;
    logic [3:0]       reg_addr;
    logic [NPADS-1:0] reg_wdata;
    logic [NPADS-1:0] reg_rdata;
    logic             reg_ack;

    modport master (
        output reg_cs, reg_wr, reg_addr, reg_wdata,
        input  reg_rdata, reg_ack
    );

    modport slave (
        input  reg_cs, reg_wr, reg_addr, reg_wdata,
        output reg_rdata, reg_ack
    );
endinterface

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl
//   Register-programmed control stage for one bank of openframe GPIO pads.
//   Drives per-pad output value, output enable (active low), input disable and
//   drive mode; synchronizes pad inputs, captures enabled edges into sticky
//   write-1-to-clear status and raises a level interrupt.
// Ports
//   mclk        : core clock, all state on the rising edge
//   reset       : synchronous, active-high reset
//   bus         : register bus (slave side)
//   pad_in      : raw asynchronous pad inputs
//   pad_out     : pad output value
//   pad_oeb     : output enable, active low
//   pad_inp_dis : input buffer disable
//   pad_dm2/1/0 : drive-mode bits per pad
//   irq         : level interrupt
module gpio_pad_ctrl #(
    parameter int NPADS = 6
) (
    input  logic                  mclk,
    input  logic                  reset,
    gpio_pad_ctrl_if.slave        bus,
    input  logic [NPADS-1:0]      pad_in,
    output logic [NPADS-1:0]      pad_out,
    output logic [NPADS-1:0]      pad_oeb,
    output logic [NPADS-1:0]      pad_inp_dis,
    output logic [NPADS-1:0]      pad_dm2,
    output logic [NPADS-1:0]      pad_dm1,
    output logic [NPADS-1:0]      pad_dm0,
    output logic                  irq
);

    localparam logic [3:0] ADDR_DOUT     = 4'd0;
    localparam logic [3:0] ADDR_OE       = 4'd1;
    localparam logic [3:0] ADDR_DIN      = 4'd2;
    localparam logic [3:0] ADDR_INP_DIS  = 4'd3;
    localparam logic [3:0] ADDR_PULL_EN  = 4'd4;
    localparam logic [3:0] ADDR_PULL_UP  = 4'd5;
    localparam logic [3:0] ADDR_RISE_EN  = 4'd6;
    localparam logic [3:0] ADDR_FALL_EN  = 4'd7;
    localparam logic [3:0] ADDR_INT_STAT = 4'd8;

    localparam logic [NPADS-1:0] ZERO = {NPADS{1'b0}};

    logic [NPADS-1:0] dout_r, oe_r, inp_dis_r, pull_en_r, pull_up_r;
    logic [NPADS-1:0] rise_en_r, fall_en_r, int_stat_r;
    logic [NPADS-1:0] s1_r, s2_r, s3_r;
    logic [NPADS-1:0] rdata_r;
    logic             ack_r;
    logic             irq_r;

    logic             accept_s;
    logic             wr_s;
    logic [NPADS-1:0] rd_mux_s;
    logic [NPADS-1:0] edge_set_s;
    logic [NPADS-1:0] w1c_clr_s;

    // A new access is taken only while no acknowledge is outstanding,
    // which gives a held request an ack every second cycle.
    assign accept_s   = bus.reg_cs & ~ack_r;
    assign wr_s       = accept_s & bus.reg_wr;
    assign edge_set_s = (s2_r & ~s3_r & rise_en_r) | (~s2_r & s3_r & fall_en_r);

    // Read multiplexer; unmapped addresses return zero.
    always_comb begin
        rd_mux_s = ZERO;
        case (bus.reg_addr)
            ADDR_DOUT:     rd_mux_s = dout_r;
            ADDR_OE:       rd_mux_s = oe_r;
            ADDR_DIN:      rd_mux_s = s2_r;
            ADDR_INP_DIS:  rd_mux_s = inp_dis_r;
            ADDR_PULL_EN:  rd_mux_s = pull_en_r;
            ADDR_PULL_UP:  rd_mux_s = pull_up_r;
            ADDR_RISE_EN:  rd_mux_s = rise_en_r;
            ADDR_FALL_EN:  rd_mux_s = fall_en_r;
            ADDR_INT_STAT: rd_mux_s = int_stat_r;
            default:       rd_mux_s = ZERO;
        endcase
    end

    // Write-1-to-clear mask for the status register, active only on an accepted write.
    always_comb begin
        w1c_clr_s = ZERO;
        if (wr_s && (bus.reg_addr == ADDR_INT_STAT)) begin
            w1c_clr_s = bus.reg_wdata;
        end else begin
            w1c_clr_s = ZERO;
        end
    end

    // Register file, bus handshake, status and interrupt state.
    always_ff @(posedge mclk) begin
        if (reset) begin
            dout_r     <= ZERO;
            oe_r       <= ZERO;
            inp_dis_r  <= ZERO;
            pull_en_r  <= ZERO;
            pull_up_r  <= ZERO;
            rise_en_r  <= ZERO;
            fall_en_r  <= ZERO;
            int_stat_r <= ZERO;
            rdata_r    <= ZERO;
            ack_r      <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            ack_r <= accept_s;
            if (accept_s) begin
                rdata_r <= rd_mux_s;
            end
            if (wr_s) begin
                case (bus.reg_addr)
                    ADDR_DOUT:    dout_r    <= bus.reg_wdata;
                    ADDR_OE:      oe_r      <= bus.reg_wdata;
                    ADDR_INP_DIS: inp_dis_r <= bus.reg_wdata;
                    ADDR_PULL_EN: pull_en_r <= bus.reg_wdata;
                    ADDR_PULL_UP: pull_up_r <= bus.reg_wdata;
                    ADDR_RISE_EN: rise_en_r <= bus.reg_wdata;
                    ADDR_FALL_EN: fall_en_r <= bus.reg_wdata;
                    default:      ;
                endcase
            end
            // New edges are ORed in after the clear so a coincident edge wins.
            int_stat_r <= (int_stat_r & ~w1c_clr_s) | edge_set_s;
            irq_r      <= |(int_stat_r & (rise_en_r | fall_en_r));
        end
    end

    // Input synchronizer plus one history stage for edge detection.
    always_ff @(posedge mclk) begin
        if (reset) begin
            s1_r <= ZERO;
            s2_r <= ZERO;
            s3_r <= ZERO;
        end else begin
            s1_r <= pad_in & ~inp_dis_r;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Per-pad drive mode and output value from the control registers.
    always_comb begin
        pad_out = ZERO;
        pad_dm2 = ZERO;
        pad_dm1 = ZERO;
        pad_dm0 = ZERO;
        for (int i = 0; i < NPADS; i++) begin
            if (oe_r[i]) begin
                pad_dm2[i] = 1'b1;
                pad_dm1[i] = 1'b1;
                pad_dm0[i] = 1'b0;
                pad_out[i] = dout_r[i];
            end else if (pull_en_r[i]) begin
                pad_dm2[i] = 1'b0;
                pad_dm1[i] = 1'b1;
                if (pull_up_r[i]) begin
                    pad_dm0[i] = 1'b1;
                    pad_out[i] = 1'b1;
                end else begin
                    pad_dm0[i] = 1'b0;
                    pad_out[i] = 1'b0;
                end
            end else begin
                pad_dm2[i] = 1'b0;
                pad_dm1[i] = 1'b0;
                pad_dm0[i] = 1'b1;
                pad_out[i] = dout_r[i];
            end
        end
    end

    assign pad_oeb       = ~oe_r;
    assign pad_inp_dis   = inp_dis_r;
    assign irq           = irq_r;
    assign bus.reg_ack   = ack_r;
    assign bus.reg_rdata = rdata_r;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb_gpio_pad_ctrl
//   Randomized and directed stimulus for gpio_pad_ctrl. A reference model holds
//   the register contents as an address-indexed array and the input history as
//   a short queue; expected read data is queued on each accepted access and a
//   monitor pops and compares it whenever the DUT acknowledges.
module tb_gpio_pad_ctrl;

    localparam int N = 6;
    localparam logic [N-1:0] ALL1 = {N{1'b1}};
    localparam logic [N-1:0] ALL0 = {N{1'b0}};

    typedef struct packed {
        logic         rd;
        logic [3:0]   addr;
        logic [N-1:0] data;
    } sb_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] pad_in;
    logic [N-1:0] pad_out, pad_oeb, pad_inp_dis, pad_dm2, pad_dm1, pad_dm0;
    logic         irq;

    gpio_pad_ctrl_if #(.NPADS(N)) bus_if ();

    gpio_pad_ctrl #(.NPADS(N)) dut (
        .mclk        (clk),
        .reset       (reset),
        .bus         (bus_if.slave),
        .pad_in      (pad_in),
        .pad_out     (pad_out),
        .pad_oeb     (pad_oeb),
        .pad_inp_dis (pad_inp_dis),
        .pad_dm2     (pad_dm2),
        .pad_dm1     (pad_dm1),
        .pad_dm0     (pad_dm0),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;

    // Reference model state
    logic [N-1:0] m_reg [0:8];
    logic [N-1:0] hist [$];   // hist[0] newest sample, hist[1] = DIN, hist[2] one older
    logic         m_ack;
    logic         m_irq;
    logic         started = 1'b0;
    sb_t          sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_read(input logic [3:0] a);
        if (a == 4'd2) return hist[1];
        if (a <= 4'd8) return m_reg[a];
        return ALL0;
    endfunction

    // Expected pad outputs {out, oeb, inp_dis, dm2, dm1, dm0} from the drive table.
    function automatic logic [6*N-1:0] model_pads();
        logic [N-1:0] o, d2, d1, d0;
        for (int i = 0; i < N; i++) begin
            logic [2:0] dm;
            logic       v;
            if (m_reg[1][i])      begin dm = 3'b110; v = m_reg[0][i]; end
            else if (!m_reg[4][i]) begin dm = 3'b001; v = m_reg[0][i]; end
            else if (m_reg[5][i])  begin dm = 3'b011; v = 1'b1; end
            else                   begin dm = 3'b010; v = 1'b0; end
            o[i] = v; d2[i] = dm[2]; d1[i] = dm[1]; d0[i] = dm[0];
        end
        return {o, ~m_reg[1], m_reg[3], d2, d1, d0};
    endfunction

    task automatic model_reset();
        for (int a = 0; a <= 8; a++) m_reg[a] = ALL0;
        hist.delete();
        for (int k = 0; k < 3; k++) hist.push_back(ALL0);
        m_ack = 1'b0;
        m_irq = 1'b0;
        sb_q.delete();
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_edge();
        logic [N-1:0] set_v, clr_v, stat_old, sample;
        logic         acc;
        if (reset) begin
            model_reset();
        end else begin
            acc      = bus_if.reg_cs && !m_ack;
            stat_old = m_reg[8];
            set_v    = (hist[1] & ~hist[2] & m_reg[6]) | (~hist[1] & hist[2] & m_reg[7]);
            clr_v    = ALL0;
            sample   = pad_in & ~m_reg[3];
            m_irq    = |(stat_old & (m_reg[6] | m_reg[7]));
            if (acc) begin
                sb_q.push_back('{rd: !bus_if.reg_wr, addr: bus_if.reg_addr,
                                 data: model_read(bus_if.reg_addr)});
                if (bus_if.reg_wr) begin
                    if (bus_if.reg_addr == 4'd8) clr_v = bus_if.reg_wdata;
                    else if (bus_if.reg_addr <= 4'd7 && bus_if.reg_addr != 4'd2)
                        m_reg[bus_if.reg_addr] = bus_if.reg_wdata;
                end
            end
            m_reg[8] = (stat_old & ~clr_v) | set_v;
            m_ack    = acc;
            hist.push_front(sample);
            void'(hist.pop_back());
        end
        started = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic bus_idle();
        bus_if.reg_cs = 1'b0; bus_if.reg_wr = 1'b0;
        bus_if.reg_addr = 4'd0; bus_if.reg_wdata = ALL0;
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [N-1:0] d);
        bus_if.reg_cs = 1'b1; bus_if.reg_wr = 1'b1; bus_if.reg_addr = a; bus_if.reg_wdata = d;
        tick();
        bus_idle();
        tick();
    endtask

    task automatic reg_read(input logic [3:0] a);
        bus_if.reg_cs = 1'b1; bus_if.reg_wr = 1'b0; bus_if.reg_addr = a; bus_if.reg_wdata = ALL0;
        tick();
        bus_idle();
        tick();
    endtask

    // Monitor: every cycle compare pad outputs, ack and irq against the model,
    // and pop the scoreboard whenever the DUT acknowledges an access.
    always @(negedge clk) begin
        if (started) begin
            chk("pads", {pad_out, pad_oeb, pad_inp_dis, pad_dm2, pad_dm1, pad_dm0}, model_pads());
            chk("reg_ack", bus_if.reg_ack, m_ack);
            chk("irq", irq, m_irq);
            if (bus_if.reg_ack === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("ack_unexpected", 32'd1, 32'd0);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    if (e.rd) chk($sformatf("rdata[%0d]", e.addr), bus_if.reg_rdata, e.data);
                end
            end
        end
    end

    initial begin
        int acks;
        model_reset();
        bus_idle();
        pad_in = ALL0;
        reset  = 1'b1;

        // T1: reset for two cycles, then read every address
        tick(); tick();
        reset = 1'b0;
        chk("t1_oeb", pad_oeb, ALL1);
        chk("t1_dm0", pad_dm0, ALL1);
        chk("t1_dm21", {pad_dm2, pad_dm1}, {2*N{1'b0}});
        chk("t1_ack_irq", {bus_if.reg_ack, irq}, 2'b00);
        for (int a = 0; a < 16; a++) reg_read(a[3:0]);

        // T2: all pads driven
        reg_write(4'd1, 6'h3F);
        reg_write(4'd0, 6'h15);
        chk("t2_oeb", pad_oeb, 6'h00);
        chk("t2_out", pad_out, 6'h15);
        chk("t2_dm", {pad_dm2, pad_dm1, pad_dm0}, {6'h3F, 6'h3F, 6'h00});

        // T3: pulls
        reg_write(4'd1, 6'h00);
        reg_write(4'd4, 6'h03);
        reg_write(4'd5, 6'h01);
        chk("t3_dm", {pad_dm2, pad_dm1, pad_dm0}, {6'h00, 6'h03, 6'h3D});
        chk("t3_out", pad_out, 6'h15 & 6'h3C | 6'h01);

        // T4: rising edge on pad2 -> status after 3 edges, irq after 4
        reg_write(4'd6, 6'h04);
        pad_in = 6'h04;
        tick(); tick(); tick();
        chk("t4_irq_early", irq, 1'b0);
        tick();
        chk("t4_irq", irq, 1'b1);
        reg_read(4'd8);
        reg_write(4'd8, 6'h04);
        chk("t4_irq_clr", irq, 1'b0);

        // T5: W1C of bit0 on the same edge a fall on pad0 is detected
        reg_write(4'd7, 6'h01);
        pad_in = 6'h05;
        repeat (4) tick();
        pad_in = 6'h04;
        tick(); tick();
        bus_if.reg_cs = 1'b1; bus_if.reg_wr = 1'b1;
        bus_if.reg_addr = 4'd8; bus_if.reg_wdata = 6'h01;
        tick();
        bus_idle();
        tick();
        reg_read(4'd8);
        reg_write(4'd8, 6'h3F);

        // T6: held request gives an ack every second cycle
        acks = 0;
        bus_if.reg_cs = 1'b1; bus_if.reg_wr = 1'b0; bus_if.reg_addr = 4'd6;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus_if.reg_ack === 1'b1) acks++;
        end
        bus_idle();
        tick();
        chk("t6_acks", acks, 3);
        // Reset in the ack-pending cycle drops the ack and the written value
        bus_if.reg_cs = 1'b1; bus_if.reg_wr = 1'b1;
        bus_if.reg_addr = 4'd1; bus_if.reg_wdata = 6'h3F;
        tick();
        bus_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_ack_drop", bus_if.reg_ack, 1'b0);
        chk("t6_oe_reset", pad_oeb, ALL1);
        reg_read(4'd1);

        // Random traffic with occasional resets
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) pad_in = N'($urandom);
            reset = ($urandom_range(0, 299) == 0);
            bus_if.reg_cs    = ($urandom_range(0, 1) == 1);
            bus_if.reg_wr    = ($urandom_range(0, 2) == 0);
            bus_if.reg_addr  = 4'($urandom_range(0, 15));
            bus_if.reg_wdata = N'($urandom);
            tick();
        end
        reset = 1'b0;
        bus_idle();
        tick(); tick(); tick();
        chk("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
